flash_read_arbiter: RTL and testbench
=====================================

FLASH_READ_ARBITER -- requirements
Module: flash_read_arbiter

Interface
REQ-001 The parameter STARTUP_WAIT SHALL default to 32'd10000000 and set the idle cycles after reset before the first flash access.
REQ-002 The parameter CS_HIGH SHALL default to 4 and set the minimum clk cycles flashCs stays high between transactions.
REQ-003 The port clk SHALL be an input of width 1 carrying the 27 MHz system clock; all logic is on its rising edge.
REQ-004 The port rst SHALL be an input of width 1; it is a synchronous, active-high reset.
REQ-005 The port flashClk SHALL be an output of width 1 carrying the SPI clock (mode 0).
REQ-006 The port flashMiso SHALL be an input of width 1 carrying SPI data from the flash.
REQ-007 The port flashMosi SHALL be an output of width 1 carrying SPI data to the flash.
REQ-008 The port flashCs SHALL be an output of width 1 carrying the SPI chip select, active low.
REQ-009 The ports req0_valid and req1_valid SHALL be inputs of width 1; each marks a pending read request.
REQ-010 The ports req0_addr and req1_addr SHALL be inputs of width 24 giving the flash start byte address.
REQ-011 The ports req0_len and req1_len SHALL be inputs of width 8 giving the byte count; 0 means 256.
REQ-012 The ports req0_ready and req1_ready SHALL be outputs of width 1 carrying the one-cycle accept strobe.
REQ-013 The port rd_data SHALL be an output of width 8 carrying a returned byte.
REQ-014 The ports rd_valid, rd_last and rd_id SHALL be outputs of width 1 meaning byte strobe, final byte of the transaction, and owning requester, respectively.
REQ-015 The port busy SHALL be an output of width 1 that is high whenever the state is not IDLE.

Function
REQ-016 The state machine SHALL have the states STARTUP, IDLE, CMD, ADDR, READ and GAP.
REQ-017 STARTUP SHALL count STARTUP_WAIT cycles with flashCs=1 and flashClk=0, then enter IDLE.
REQ-018 In IDLE, when any reqN_valid is high and no ready was issued in the previous cycle, the block SHALL assert exactly one reqN_ready for one cycle and latch that requester's addr, len and id in the same cycle.
REQ-019 Arbitration SHALL be round-robin: when both requesters are valid, the grant goes to the requester not granted last; the first contest after reset goes to req0.
REQ-020 A requester SHALL hold valid, addr and len stable until it sees ready; valid deassertion without ready is legal and is never granted.
REQ-021 In the cycle after ready, the block SHALL drive flashCs=0 and enter CMD, shifting 0x03 MSB first, then ADDR shifting the 24-bit address MSB first, then READ.
REQ-022 Each SPI bit SHALL take 2 clk cycles: a low phase (flashClk=0, flashMosi updated) followed by a high phase (flashClk=1).
REQ-023 flashMiso SHALL be sampled on the clk edge that raises flashClk.
REQ-024 flashMosi SHALL be held at 0 during READ.
REQ-025 The command and address SHALL occupy exactly 64 clk cycles.
REQ-026 Each read byte SHALL take 16 cycles; rd_valid SHALL pulse for one cycle, on the cycle after the byte's 8th sample, with rd_data equal to the byte MSB first and rd_id equal to the latched id.
REQ-027 rd_last SHALL be high only with rd_valid on byte number len (or 256 when len=0).
REQ-028 There is no backpressure on the rd_* outputs.
REQ-029 After the final byte, the block SHALL hold flashClk=0 and raise flashCs=1 in the following cycle, then remain in GAP for CS_HIGH cycles before returning to IDLE.
REQ-030 A request arriving during a transaction SHALL wait in IDLE for arbitration and SHALL never be dropped.
REQ-031 The byte counter SHALL be 9 bits so that len=0 yields 256 bytes.
REQ-032 The address SHALL be sent as given; wrap at the flash top is the flash's behaviour.

Reset
REQ-033 On rst, the state SHALL become STARTUP, with flashCs=1, flashClk=0, flashMosi=0, both readies 0, rd_valid=0, rd_last=0, rd_data=0, rd_id=0, busy=1, and the round-robin pointer pointing to req0.
REQ-034 A reset asserted mid-transaction SHALL abort it in the next cycle, raising flashCs with no further rd_valid, and SHALL rerun STARTUP.

Verification (STARTUP_WAIT=16, CS_HIGH=4, SPI flash model)
REQ-035 Reset, then req0 addr 0x000100 len 1 -> ready after STARTUP; MOSI bits 0x03,0x00,0x01,0x00; one rd_valid with rd_last=1, rd_id=0, rd_data = model[0x100], 81 cycles after ready.
REQ-036 Both requesters valid in the same cycle (req0 len 2, req1 len 3) -> req0 served first with 2 bytes, then after the GAP req1 with 3 bytes and rd_id=1; a repeat contest grants req0 again (req1 was granted last).
REQ-037 req1 len 0 at addr 0x00FF00 -> 256 rd_valid pulses, rd_last only on the 256th, data = model[0x00FF00..0x00FFFF].
REQ-038 rst asserted on the 40th cycle of READ -> flashCs=1 the next cycle, no further rd_valid, STARTUP reruns, and a new request completes correctly.
REQ-039 req0_valid pulsed high and then low while busy -> never granted; the flashCs high time between transactions is always at least 4 cycles.

Source files
------------

// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: round-robin arbiter of two byte-read requesters onto one SPI flash (0x03 read, mode 0)
module flash_read_arbiter #(
  parameter logic [31:0] STARTUP_WAIT = 32'd10000000,
  parameter int CS_HIGH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        flashClk,
  input  logic        flashMiso,
  output logic        flashMosi,
  output logic        flashCs,
  input  logic        req0_valid,
  input  logic [23:0] req0_addr,
  input  logic [7:0]  req0_len,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [23:0] req1_addr,
  input  logic [7:0]  req1_len,
  output logic        req1_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        rd_last,
  output logic        rd_id,
  output logic        busy
);
  typedef enum logic [2:0] {STARTUP, IDLE, CMD, ADDR, READ, GAP} state_t;
  state_t state, state_nx;
  logic [31:0] cnt;
  logic [31:0] sr;
  logic [6:0] rx;
  logic [8:0] left;
  logic [23:0] addr_sel;
  logic [7:0] len_sel;
  logic id, prio, ready_q, grant1, take, shifting, byte_done;
  assign grant1 = req1_valid & (~req0_valid | prio);
  assign take = (state == IDLE) & ~ready_q & (req0_valid | req1_valid);
  assign req0_ready = take & ~grant1;
  assign req1_ready = take & grant1;
  assign addr_sel = grant1 ? req1_addr : req0_addr;
  assign len_sel = grant1 ? req1_len : req0_len;
  assign shifting = (state == CMD) | (state == ADDR);
  assign byte_done = (state == READ) & (cnt[3:0] == 4'd14);
  assign busy = state != IDLE;
  assign flashCs = state inside {STARTUP, IDLE, GAP};
  assign flashClk = shifting ? (cnt != 32'd0) & ~cnt[0] : (state == READ) & cnt[0];
  assign flashMosi = shifting & sr[31];
  assign rd_id = id;
  always_comb begin
    state_nx = state;
    case (state)
      STARTUP: state_nx = (cnt + 32'd1 >= STARTUP_WAIT) ? IDLE : STARTUP;
      IDLE:    state_nx = take ? CMD : IDLE;
      CMD:     state_nx = (cnt == 32'd16) ? ADDR : CMD;
      ADDR:    state_nx = (cnt == 32'd64) ? READ : ADDR;
      READ:    state_nx = (cnt[3:0] == 4'd15 && left == 9'd1) ? GAP : READ;
      GAP:     state_nx = (cnt + 32'd1 >= 32'(CS_HIGH)) ? IDLE : GAP;
      default: state_nx = STARTUP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STARTUP;
      cnt <= '0;
      sr <= '0;
      rx <= '0;
      left <= '0;
      id <= 1'b0;
      prio <= 1'b0;
      ready_q <= 1'b0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= (state_nx != state && state_nx != ADDR) ? '0 : cnt + 32'd1;
      ready_q <= take;
      rd_valid <= byte_done;
      rd_last <= byte_done & (left == 9'd1);
      if (take) begin
        id <= grant1;
        prio <= ~grant1;
        sr <= {8'h03, addr_sel};
        left <= {~|len_sel, len_sel};
      end
      if (shifting && cnt != 32'd0 && !cnt[0]) sr <= {sr[30:0], 1'b0};
      if (state == READ && !cnt[0]) rx <= {rx[5:0], flashMiso};
      if (byte_done) rd_data <= {rx, flashMiso};
      if (state == READ && cnt[3:0] == 4'd15) left <= left - 9'd1;
    end
  end
endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb_flash_read_arbiter: SPI flash model, byte scoreboard and round-robin reference checking flash_read_arbiter
module tb_flash_read_arbiter;
  typedef struct {logic id; logic [7:0] data; logic last;} byte_t;
  typedef struct {logic id; logic [23:0] addr; logic [7:0] len; int nbytes;} vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic flash_clk, flash_mosi, flash_cs, flash_miso = 1'b0;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [23:0] req0_addr, req1_addr;
  logic [7:0] req0_len, req1_len, rd_data;
  logic rd_valid, rd_last, rd_id, busy;
  int checks = 0, errors = 0, cyc = 0, rst_cyc = 0, ready_cyc = 0, rdv_cyc = 0;
  int nb = 0, nl = 0, g0 = 0, g1 = 0, fm_nb = 0, cs_hi = 0;
  logic last_id, rr_last = 1'b1, prev_rdy = 1'b0, prev_cs = 1'b1, mon_en = 1'b0;
  logic [7:0] last_data;
  byte_t exp_q[$];
  logic [31:0] cmd_q[$];
  flash_read_arbiter #(.STARTUP_WAIT(32'd16), .CS_HIGH(4)) dut (
    .clk(clk), .rst(rst), .flashClk(flash_clk), .flashMiso(flash_miso), .flashMosi(flash_mosi),
    .flashCs(flash_cs), .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len),
    .req0_ready(req0_ready), .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len),
    .req1_ready(req1_ready), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .rd_id(rd_id), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] mem(input logic [23:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h5A;
  endfunction
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction
  logic [31:0] fm_ca;
  logic [7:0] fm_byte;
  int fm_k;
  always @(posedge flash_cs) fm_nb = 0;
  always @(posedge flash_clk) if (flash_cs === 1'b0) begin
    if (fm_nb < 32) fm_ca = {fm_ca[30:0], flash_mosi};
    fm_nb++;
    if (fm_nb == 32) begin
      if (cmd_q.size() > 0) chk("spi_cmd_addr", fm_ca, cmd_q.pop_front());
      else begin
        checks++;
        errors++;
        $display("FAIL spi_cmd_addr: got %0h with no transaction granted", fm_ca);
      end
    end
  end
  always @(negedge flash_clk) if (flash_cs === 1'b0 && fm_nb >= 32) begin
    fm_k = fm_nb - 32;
    fm_byte = mem(24'(fm_ca[23:0] + 24'(fm_k / 8)));
    flash_miso = fm_byte[7 - fm_k % 8];
  end
  logic gid, g_exp, exp_rdy;
  logic [23:0] m_addr;
  int m_n;
  byte_t e;
  always @(negedge clk) if (mon_en) begin
    exp_rdy = !busy && !prev_rdy && !rst && (req0_valid || req1_valid);
    if (exp_rdy || req0_ready || req1_ready) chk("ready_when_idle", req0_ready | req1_ready, exp_rdy);
    if (req0_ready || req1_ready) begin
      chk("ready_onehot", req0_ready & req1_ready, 0);
      gid = req1_ready;
      chk("ready_needs_valid", gid ? req1_valid : req0_valid, 1);
      g_exp = (req0_valid && req1_valid) ? ~rr_last : req1_valid;
      chk("rr_grant", gid, g_exp);
      rr_last = gid;
      if (gid) g1++; else g0++;
      m_addr = gid ? req1_addr : req0_addr;
      m_n = (gid ? req1_len : req0_len) == 8'd0 ? 256 : int'(gid ? req1_len : req0_len);
      cmd_q.push_back({8'h03, m_addr});
      for (int i = 0; i < m_n; i++) exp_q.push_back('{gid, mem(24'(m_addr + 24'(i))), i == m_n - 1});
      ready_cyc = cyc;
    end
    prev_rdy = req0_ready | req1_ready;
    if (rd_valid) begin
      nb++;
      if (rd_last) nl++;
      last_id = rd_id;
      last_data = rd_data;
      rdv_cyc = cyc;
      if (exp_q.size() == 0) chk("rd_unexpected", rd_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("rd_data", rd_data, e.data);
        chk("rd_id", rd_id, e.id);
        chk("rd_last", rd_last, e.last);
      end
    end else if (rd_last) chk("rd_last_alone", rd_last, 0);
    if (flash_cs) begin
      cs_hi++;
      if (flash_clk) chk("clk_low_when_cs_high", flash_clk, 0);
    end else begin
      if (prev_cs) begin
        checks++;
        if (cs_hi < 4) begin
          errors++;
          $display("FAIL cs_high_time: got %0d cycles, expected >= 4", cs_hi);
        end
      end
      cs_hi = 0;
    end
    prev_cs = flash_cs;
  end
  task automatic release_rst();
    #1;
    rst = 1'b0;
    exp_q.delete();
    cmd_q.delete();
    rr_last = 1'b1;
    prev_rdy = 1'b0;
    rst_cyc = cyc;
  endtask
  task automatic wait_rdy(input logic r);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(r ? req1_ready : req0_ready) && n < 10000);
    if (n >= 10000) begin
      checks++;
      errors++;
      $display("FAIL wait_ready%0d: no ready within %0d cycles", r, n);
    end
  endtask
  task automatic wait_any();
    int n = 0;
    do begin @(negedge clk); n++; end while (!(req0_ready || req1_ready) && n < 200);
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_any_ready: no ready within %0d cycles", n);
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 8000);
    chk("idle_reached", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask
  task automatic issue(input logic r, input logic [23:0] a, input logic [7:0] l);
    if (r) begin req1_addr = a; req1_len = l; req1_valid = 1'b1; end
    else begin req0_addr = a; req0_len = l; req0_valid = 1'b1; end
    wait_rdy(r);
    @(posedge clk);
    #1;
    if (r) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask
  vec_t tbl[5];
  int snap, n;
  initial begin
    tbl[0] = '{1'b1, 24'h123456, 8'd3, 3};
    tbl[1] = '{1'b0, 24'hFFFFFE, 8'd4, 4};
    tbl[2] = '{1'b1, 24'h00FF00, 8'd0, 256};
    tbl[3] = '{1'b0, 24'hABCDEF, 8'd1, 1};
    tbl[4] = '{1'b1, 24'h000000, 8'd16, 16};
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = '0; req1_addr = '0; req0_len = '0; req1_len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_flashCs", flash_cs, 1);
    chk("rst_flashClk", flash_clk, 0);
    chk("rst_flashMosi", flash_mosi, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_id", rd_id, 0);
    chk("rst_busy", busy, 1);
    @(posedge clk);
    release_rst();
    mon_en = 1'b1;
    req0_addr = 24'h000100; req0_len = 8'd1; req0_valid = 1'b1;
    wait_rdy(0);
    chk("startup_cycles", cyc - rst_cyc, 16);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    wait_idle();
    chk("first_byte_latency", rdv_cyc - ready_cyc, 81);
    chk("len1_bytes", nb, 1);
    chk("len1_lasts", nl, 1);
    chk("len1_id", last_id, 0);
    chk("len1_data", last_data, mem(24'h000100));
    for (int i = 0; i < 5; i++) begin
      nb = 0; nl = 0;
      @(posedge clk);
      #1;
      issue(tbl[i].id, tbl[i].addr, tbl[i].len);
      wait_idle();
      chk("vec_bytes", nb, tbl[i].nbytes);
      chk("vec_lasts", nl, 1);
      chk("vec_id", last_id, tbl[i].id);
    end
    nb = 0;
    @(posedge clk);
    #1;
    issue(0, 24'h012345, 8'd8);
    n = 0;
    while (fm_nb < 32 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    repeat (39) @(posedge clk);
    #1;
    rst = 1'b1;
    snap = nb;
    chk("bytes_before_abort", snap, 2);
    @(posedge clk);
    release_rst();
    req0_addr = 24'h000200; req0_len = 8'd2; req0_valid = 1'b1;
    @(negedge clk);
    chk("abort_flashCs", flash_cs, 1);
    chk("abort_busy", busy, 1);
    wait_rdy(0);
    chk("restart_cycles", cyc - rst_cyc, 16);
    chk("abort_no_rd", nb - snap, 0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    wait_idle();
    chk("restart_bytes", nb - snap, 2);
    chk("restart_id", last_id, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    release_rst();
    nb = 0; nl = 0;
    req0_addr = 24'h00A000; req0_len = 8'd2; req1_addr = 24'h00B000; req1_len = 8'd3;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_any();
    chk("contest_first", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    wait_rdy(1);
    chk("contest_serial", nb, 2);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    wait_idle();
    chk("contest_bytes", nb, 5);
    chk("contest_lasts", nl, 2);
    chk("contest_id", last_id, 1);
    @(posedge clk);
    #1;
    req0_addr = 24'h00A100; req0_len = 8'd1; req1_addr = 24'h00B100; req1_len = 8'd1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_any();
    chk("contest_repeat", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    wait_rdy(1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    wait_idle();
    @(posedge clk);
    #1;
    issue(1, 24'h00C000, 8'd2);
    snap = g0;
    req0_addr = 24'h00D000; req0_len = 8'd1; req0_valid = 1'b1;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    chk("pulse_not_granted", g0 - snap, 0);
    @(posedge clk);
    #1;
    fork
      repeat (8) begin
        repeat ($urandom_range(0, 40)) @(posedge clk);
        #1;
        issue(0, 24'($urandom), 8'($urandom_range(1, 8)));
      end
      repeat (8) begin
        repeat ($urandom_range(0, 40)) @(posedge clk);
        #1;
        issue(1, 24'($urandom), 8'($urandom_range(1, 8)));
      end
    join
    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
